cnt60x2_down: RTL and testbench
===============================

Name: cnt60x2_down

Overview:
- Countdown (kitchen-style) timer: MM:SS in BCD, 00:00 to 59:59.
- It is the down-counting counterpart to the up-counting mod-60 clock counters in the same design.
- Values are set with increment buttons, counted down on the 1 Hz enable tick, and an alarm is raised on reaching 00:00.
- Digit outputs use the same BCD split as the clock counters (3-bit tens, 4-bit units), so they feed the existing 7-segment display path directly.

Parameters:
- ALARM_TICKS, default 10: alarm duration in EN ticks. Legal range is 1 or more.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-low (0 = reset)
- EN  in  1  1 Hz tick, one CLK cycle wide
- CLR  in  1  pulse: clear to 00:00 and go to IDLE
- START_STOP  in  1  pulse: start, pause, or silence the alarm
- MIN_INC  in  1  pulse: increment minutes (IDLE only)
- SEC_INC  in  1  pulse: increment seconds (IDLE only)
- MH  out  3  minutes tens, 0-5
- ML  out  4  minutes units, 0-9
- SH  out  3  seconds tens, 0-5
- SL  out  4  seconds units, 0-9
- RUN  out  1  high while counting down
- ALARM  out  1  high while the alarm is active

Behaviour:
- Reset: on a CLK edge with RST=0:
  - MH, ML, SH, SL = 0
  - state = IDLE, alarm counter = 0
  - RUN = 0, ALARM = 0
- All outputs are registered. RUN is high exactly when state = RUN; ALARM is high exactly when state = ALARM.
- Priority order: RST, then CLR, then the state logic below.
- CLR in any state: digits go to 00:00, state goes to IDLE, alarm counter goes to 0.
- IDLE:
  - SEC_INC: seconds advance by 1, wrapping 59 to 00 with no carry into minutes.
  - MIN_INC: minutes advance by 1, wrapping 59 to 00.
  - SEC_INC and MIN_INC in the same cycle: both apply.
  - START_STOP: go to RUN if the current registered value is not 00:00; otherwise ignore it.
    - The start decision uses the pre-increment value.
    - No decrement occurs in the start cycle, even if EN is also high.
  - EN is ignored.
- RUN:
  - On each EN, decrement by 1 second:
    - If SL > 0: SL decrements.
    - Else if SH > 0: SL becomes 9, SH decrements.
    - Else (seconds = 00): seconds become 59 and minutes decrement by the same BCD rule.
  - If the decrement result is 00:00, the next state is ALARM and the alarm counter is loaded with 0.
  - START_STOP pauses: next state is IDLE and the value is held.
  - EN and START_STOP in the same cycle: the decrement applies first.
    - Result 00:00: next state is ALARM.
    - Otherwise: next state is IDLE.
  - MIN_INC and SEC_INC are ignored.
  - Underflow below 00:00 is impossible: RUN is never entered at zero, and RUN is left on reaching zero.
- ALARM:
  - Digits hold at 00:00.
  - Each EN increments the alarm counter.
  - When EN arrives with the counter at ALARM_TICKS-1, go to IDLE. ALARM is therefore high for ALARM_TICKS EN periods.
  - START_STOP returns to IDLE immediately.
  - MIN_INC and SEC_INC are ignored.
- Alarm counter width is $clog2(ALARM_TICKS+1).
- Digit registers never hold non-BCD values (tens 0-5, units 0-9).
- Latency: any input pulse is reflected on the outputs after the next CLK edge.
- Reset mid-RUN or mid-ALARM: everything returns to the reset values with no residual alarm.

Decomposition:
- Shared package:
  - State enum: IDLE, RUN, ALARM (2 bits).
  - Constants: TENS_MAX = 5, UNITS_MAX = 9.
- Sub-module cnt60_dn, instantiated twice (seconds and minutes). One mod-60 BCD field with:
  - INC: up count with wrap.
  - DEC: down count, 00 to 59.
  - CLR.
  - BR output = DEC && value == 00.
- Chaining:
  - Seconds DEC = RUN-state EN.
  - Minutes DEC = seconds BR.
- The top level holds the FSM, the alarm counter, and the zero-detect.

Test Plan:
- Reset, then 3x SEC_INC, START_STOP, 3 EN ticks:
  - Display reads 00:03, 00:02, 00:01, 00:00.
  - ALARM rises on the 3rd tick edge; RUN falls at the same edge.
- Set 01:00 (1x MIN_INC), START, 1 EN tick: display reads 00:59 (seconds borrow into minutes).
- 60x SEC_INC from 00:00: display reads 00:00 with minutes still 0 (wrap without carry). 60x MIN_INC: minutes wrap to 00.
- Alarm duration:
  - ALARM_TICKS=10: ALARM stays high for 10 EN ticks, then the FSM returns to IDLE at 00:00.
  - Repeat with START_STOP on the 2nd alarm cycle: ALARM drops after the next edge.
- Pause and resume:
  - At 00:05 in RUN, assert START_STOP together with EN: display reads 00:04, RUN=0.
  - Further EN ticks: no change.
  - START_STOP: RUN=1 and counting resumes.
- Control in non-IDLE states:
  - START_STOP at 00:00 in IDLE: stays IDLE.
  - CLR during RUN at 12:34: display reads 00:00, state IDLE.
  - RST=0 during ALARM: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/cnt60x2_down_pkg.sv
// Shared types and digit limits for the MM:SS countdown timer.
// Pure declarations: no latency, no flow control.
package cnt60x2_down_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam logic [2:0] TENS_MAX  = 3'd5;
    localparam logic [3:0] UNITS_MAX = 4'd9;

endpackage

// File: rtl/cnt60x2_down_cnt60_dn.sv
// One mod-60 BCD field (tens 0-5, units 0-9) with up/down count and clear.
// Registered digits update on the next clk edge; no backpressure, br is combinational.
module cnt60x2_down_cnt60_dn
    import cnt60x2_down_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [2:0] tens,
    output logic [3:0] units,
    output logic       br
);

    // Borrow out: this field wraps 00 -> 59 on this decrement.
    assign br = dec && (tens == 3'd0) && (units == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tens  <= 3'd0;
            units <= 4'd0;
        end else if (clr) begin
            tens  <= 3'd0;
            units <= 4'd0;
        end else if (dec) begin
            if (units != 4'd0) begin
                units <= units - 4'd1;
            end else if (tens != 3'd0) begin
                units <= UNITS_MAX;
                tens  <= tens - 3'd1;
            end else begin
                units <= UNITS_MAX;
                tens  <= TENS_MAX;
            end
        end else if (inc) begin
            if (units == UNITS_MAX) begin
                units <= 4'd0;
                tens  <= (tens == TENS_MAX) ? 3'd0 : tens + 3'd1;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/cnt60x2_down.sv
// Kitchen countdown timer MM:SS (BCD) with set buttons, 1 Hz countdown and timed alarm.
// Every input pulse is reflected on the registered outputs after the next CLK edge; no backpressure.
module cnt60x2_down
    import cnt60x2_down_pkg::*;
#(
    parameter int ALARM_TICKS = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       CLR,
    input  logic       START_STOP,
    input  logic       MIN_INC,
    input  logic       SEC_INC,
    output logic [2:0] MH,
    output logic [3:0] ML,
    output logic [2:0] SH,
    output logic [3:0] SL,
    output logic       RUN,
    output logic       ALARM
);

    localparam int ACW = $clog2(ALARM_TICKS + 1);
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_TICKS - 1);

    state_t         state;
    state_t         state_nxt;
    logic [ACW-1:0] alarm_cnt;
    logic [ACW-1:0] alarm_cnt_nxt;

    logic is_zero;
    logic is_one;
    logic sec_inc;
    logic min_inc;
    logic sec_dec;
    logic sec_br;
    logic min_br;

    assign is_zero = (MH == 3'd0) && (ML == 4'd0) && (SH == 3'd0) && (SL == 4'd0);
    assign is_one  = (MH == 3'd0) && (ML == 4'd0) && (SH == 3'd0) && (SL == 4'd1);

    assign sec_inc = (state == ST_IDLE) && SEC_INC;
    assign min_inc = (state == ST_IDLE) && MIN_INC;
    assign sec_dec = (state == ST_RUN) && EN;

    cnt60x2_down_cnt60_dn u_sec (
        .clk   (CLK),
        .rst   (RST),
        .clr   (CLR),
        .inc   (sec_inc),
        .dec   (sec_dec),
        .tens  (SH),
        .units (SL),
        .br    (sec_br)
    );

    cnt60x2_down_cnt60_dn u_min (
        .clk   (CLK),
        .rst   (RST),
        .clr   (CLR),
        .inc   (min_inc),
        .dec   (sec_br),
        .tens  (MH),
        .units (ML),
        .br    (min_br)
    );

    always_comb begin
        state_nxt     = state;
        alarm_cnt_nxt = alarm_cnt;
        if (CLR) begin
            state_nxt     = ST_IDLE;
            alarm_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Start is judged on the value before any same-cycle increment.
                    if (START_STOP && !is_zero) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sec_dec && is_one) begin
                        state_nxt     = ST_ALARM;
                        alarm_cnt_nxt = '0;
                    end else if (START_STOP) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_ALARM: begin
                    if (START_STOP) begin
                        state_nxt     = ST_IDLE;
                        alarm_cnt_nxt = '0;
                    end else if (EN) begin
                        if (alarm_cnt == ALARM_LAST) begin
                            state_nxt     = ST_IDLE;
                            alarm_cnt_nxt = '0;
                        end else begin
                            alarm_cnt_nxt = alarm_cnt + ACW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt     = ST_IDLE;
                    alarm_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ST_IDLE;
            alarm_cnt <= '0;
            RUN       <= 1'b0;
            ALARM     <= 1'b0;
        end else begin
            state     <= state_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            RUN       <= (state_nxt == ST_RUN);
            ALARM     <= (state_nxt == ST_ALARM);
        end
    end

    // Minutes never borrow past 00:00, since RUN is left on reaching zero.
    logic unused_min_br;
    assign unused_min_br = min_br;

endmodule

// File: tb/tb_cnt60x2_down.sv
// Bench for cnt60x2_down: directed scenarios plus random pulses against a seconds-arithmetic model.
module tb_cnt60x2_down;

    localparam int AT = 10;

    // Stimulus codes: {rst_n, en, clr, start_stop, min_inc, sec_inc}
    localparam logic [5:0] P_RST = 6'b000000;
    localparam logic [5:0] P_NOP = 6'b100000;
    localparam logic [5:0] P_EN  = 6'b010000;
    localparam logic [5:0] P_CLR = 6'b001000;
    localparam logic [5:0] P_SS  = 6'b000100;
    localparam logic [5:0] P_MI  = 6'b000010;
    localparam logic [5:0] P_SI  = 6'b000001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       start_stop = 1'b0;
    logic       min_inc = 1'b0;
    logic       sec_inc = 1'b0;
    logic [2:0] mh;
    logic [3:0] ml;
    logic [2:0] sh;
    logic [3:0] sl;
    logic       run;
    logic       alarm;

    int total = 0;
    int bad   = 0;

    // Reference state: minutes/seconds as plain integers, state 0=idle 1=run 2=alarm.
    int m_min = 0;
    int m_sec = 0;
    int m_st  = 0;
    int m_acnt = 0;

    always #5 clk = ~clk;

    cnt60x2_down #(.ALARM_TICKS(AT)) dut (
        .CLK        (clk),
        .RST        (rst),
        .EN         (en),
        .CLR        (clr),
        .START_STOP (start_stop),
        .MIN_INC    (min_inc),
        .SEC_INC    (sec_inc),
        .MH         (mh),
        .ML         (ml),
        .SH         (sh),
        .SL         (sl),
        .RUN        (run),
        .ALARM      (alarm)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [5:0] v);
        int t;
        bit start;
        if (!v[5]) begin
            m_min = 0; m_sec = 0; m_st = 0; m_acnt = 0;
        end else if (v[3]) begin
            m_min = 0; m_sec = 0; m_st = 0; m_acnt = 0;
        end else begin
            case (m_st)
                0: begin
                    start = v[2] && (m_min * 60 + m_sec) != 0;
                    if (v[0]) m_sec = (m_sec + 1) % 60;
                    if (v[1]) m_min = (m_min + 1) % 60;
                    if (start) m_st = 1;
                end
                1: begin
                    if (v[4]) begin
                        t = m_min * 60 + m_sec - 1;
                        m_min = t / 60;
                        m_sec = t % 60;
                        if (t == 0) begin
                            m_st = 2;
                            m_acnt = 0;
                        end else if (v[2]) begin
                            m_st = 0;
                        end
                    end else if (v[2]) begin
                        m_st = 0;
                    end
                end
                default: begin
                    if (v[2]) begin
                        m_st = 0;
                        m_acnt = 0;
                    end else if (v[4]) begin
                        if (m_acnt == AT - 1) begin
                            m_st = 0;
                            m_acnt = 0;
                        end else begin
                            m_acnt++;
                        end
                    end
                end
            endcase
        end
    endtask

    function automatic int disp_val();
        return mh * 1000 + ml * 100 + sh * 10 + sl;
    endfunction

    // Apply one cycle of stimulus, advance the model, and compare after the edge.
    task automatic step(input logic [5:0] v);
        {rst, en, clr, start_stop, min_inc, sec_inc} = v;
        @(posedge clk);
        model_step(v);
        #1;
        chk("display", disp_val(), (m_min / 10) * 1000 + (m_min % 10) * 100 + m_sec);
        chk("run_alarm", {30'd0, run, alarm}, {30'd0, m_st == 1, m_st == 2});
        {rst, en, clr, start_stop, min_inc, sec_inc} = P_NOP;
    endtask

    task automatic repeat_step(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        logic [5:0] v;

        repeat_step(P_RST, 2);
        chk("reset_disp", disp_val(), 0);
        chk("reset_flags", {30'd0, run, alarm}, 0);

        // 00:03 countdown into alarm
        repeat_step(P_NOP | P_SI, 3);
        step(P_NOP | P_SS);
        chk("start_run", run, 1);
        repeat_step(P_NOP | P_EN, 2);
        chk("tick2_disp", disp_val(), 1);
        step(P_NOP | P_EN);
        chk("alarm_rise", {30'd0, run, alarm}, 1);

        // Alarm lasts AT ticks
        repeat_step(P_NOP | P_EN, AT - 1);
        chk("alarm_hold", alarm, 1);
        step(P_NOP | P_EN);
        chk("alarm_end", {30'd0, run, alarm}, 0);

        // 01:00 -> 00:59 borrow
        step(P_NOP | P_MI);
        step(P_NOP | P_SS);
        step(P_NOP | P_EN);
        chk("borrow_0059", disp_val(), 59);
        step(P_NOP | P_CLR);

        // Wrap without carry
        repeat_step(P_NOP | P_SI, 60);
        chk("sec_wrap", disp_val(), 0);
        repeat_step(P_NOP | P_MI, 60);
        chk("min_wrap", disp_val(), 0);

        // Pause with simultaneous tick, then resume
        repeat_step(P_NOP | P_SI, 5);
        step(P_NOP | P_SS);
        step(P_NOP | P_SS | P_EN);
        chk("pause_disp", disp_val(), 4);
        chk("pause_run", run, 0);
        repeat_step(P_NOP | P_EN, 3);
        chk("paused_hold", disp_val(), 4);
        step(P_NOP | P_SS);
        chk("resume_run", run, 1);
        step(P_NOP | P_EN);
        chk("resume_tick", disp_val(), 3);
        step(P_NOP | P_CLR);

        // Start at zero is ignored
        step(P_NOP | P_SS);
        chk("start_zero", run, 0);

        // CLR during RUN at 12:34
        repeat_step(P_NOP | P_MI, 12);
        repeat_step(P_NOP | P_SI, 34);
        step(P_NOP | P_SS);
        chk("set_1234", disp_val(), 1234);
        step(P_NOP | P_CLR | P_EN);
        chk("clr_run", {disp_val(), run, alarm}, 0);

        // Silence alarm on its 2nd cycle
        step(P_NOP | P_SI);
        step(P_NOP | P_SS);
        step(P_NOP | P_EN);
        step(P_NOP | P_EN);
        chk("silence_pre", alarm, 1);
        step(P_NOP | P_SS);
        chk("silence", alarm, 0);

        // Reset during alarm
        step(P_NOP | P_SI);
        step(P_NOP | P_SS);
        step(P_NOP | P_EN);
        step(P_RST | P_SS);
        chk("rst_alarm", {disp_val(), run, alarm}, 0);

        // Random pulses
        for (int i = 0; i < 4000; i++) begin
            v = P_NOP;
            if ($urandom_range(0, 299) == 0) v[5] = 1'b0;
            if ($urandom_range(0, 2) == 0) v[4] = 1'b1;
            if ($urandom_range(0, 99) == 0) v[3] = 1'b1;
            if ($urandom_range(0, 11) == 0) v[2] = 1'b1;
            if ($urandom_range(0, 7) == 0) v[1] = 1'b1;
            if ($urandom_range(0, 4) == 0) v[0] = 1'b1;
            step(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
